// File: rtl/alu_pkg.sv
// Shared opcodes, widths, FSM state type and the single-cycle ALU function
// for the execute-stage arithmetic unit.
package alu_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned SHAMT_WIDTH = 5;
  localparam int unsigned OP_WIDTH    = 4;
  localparam int unsigned LINK_OFFSET = 4;

  localparam logic [OP_WIDTH-1:0] ALU_ADD = 4'b0000;
  localparam logic [OP_WIDTH-1:0] ALU_LUI = 4'b0001;
  localparam logic [OP_WIDTH-1:0] ALU_OR  = 4'b0010;
  localparam logic [OP_WIDTH-1:0] ALU_SLL = 4'b0011;
  localparam logic [OP_WIDTH-1:0] ALU_SUB = 4'b0100;
  localparam logic [OP_WIDTH-1:0] ALU_SRL = 4'b0101;
  localparam logic [OP_WIDTH-1:0] ALU_XOR = 4'b0110;
  localparam logic [OP_WIDTH-1:0] ALU_BNE = 4'b0111;
  localparam logic [OP_WIDTH-1:0] ALU_BLT = 4'b1000;
  localparam logic [OP_WIDTH-1:0] ALU_AND = 4'b1001;
  localparam logic [OP_WIDTH-1:0] ALU_JAL = 4'b1111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_t;

  // One-cycle result for every code; shifts here are the barrel form.
  function automatic logic [DATA_WIDTH-1:0] alu_compute(
    input logic [OP_WIDTH-1:0]   op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0]  res;
    logic [SHAMT_WIDTH-1:0] shamt;
    shamt = b[SHAMT_WIDTH-1:0];
    res   = '0;
    case (op)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_BNE: res = a ^ b;
      ALU_BLT: res = DATA_WIDTH'($signed(a) < $signed(b));
      ALU_LUI: res = b;
      ALU_JAL: res = a + DATA_WIDTH'(LINK_OFFSET);
      ALU_SLL: res = a << shamt;
      ALU_SRL: res = a >> shamt;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between pipeline control (master) and the
// execute-stage ALU (slave).
interface alu_exec_unit_if;
  import alu_pkg::*;

  logic                  start_i;
  logic [OP_WIDTH-1:0]   alu_operation_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] alu_result_o;
  logic                  zero_o;

  modport master (
    output start_i, alu_operation_i, a_i, b_i,
    input  busy_o, done_o, alu_result_o, zero_o
  );

  modport slave (
    input  start_i, alu_operation_i, a_i, b_i,
    output busy_o, done_o, alu_result_o, zero_o
  );
endinterface

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter: shift register, down-counter and
// direction flag. value_c is the value after the next step.
module alu_shift_iter
  import alu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  logic [DATA_WIDTH-1:0]  load_value,
  input  logic [SHAMT_WIDTH-1:0] load_count,
  input  logic                   load_left,
  output logic [DATA_WIDTH-1:0]  value_c,
  output logic                   last_c
);

  logic [DATA_WIDTH-1:0]  shreg;
  logic [SHAMT_WIDTH-1:0] count;
  logic                   left;

  assign value_c = left ? (shreg << 1) : (shreg >> 1);
  assign last_c  = (count == SHAMT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      count <= '0;
      left  <= 1'b0;
    end else if (load) begin
      shreg <= load_value;
      count <= load_count;
      left  <= load_left;
    end else if (step) begin
      shreg <= value_c;
      count <= count - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered result/zero and a start/busy/done
// handshake. Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  alu_exec_unit_if.slave  bus
);

  logic [DATA_WIDTH-1:0] op_result_c;
  logic                  result_we_c;
  logic [DATA_WIDTH-1:0] result_d_c;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;
  logic                  done;

  assign op_result_c = alu_compute(bus.alu_operation_i, bus.a_i, bus.b_i);

`ifdef ALU_BARREL_SHIFT_EN

  always_comb begin
    result_we_c = bus.start_i;
    result_d_c  = op_result_c;
  end

  assign bus.busy_o = 1'b0;

`else

  alu_state_t             state;
  alu_state_t             state_next;
  logic [SHAMT_WIDTH-1:0] shamt_c;
  logic                   is_shift_c;
  logic                   sh_load_c;
  logic                   sh_step_c;
  logic [DATA_WIDTH-1:0]  sh_value_c;
  logic                   sh_last_c;

  assign shamt_c    = bus.b_i[SHAMT_WIDTH-1:0];
  assign is_shift_c = (bus.alu_operation_i == ALU_SLL) ||
                      (bus.alu_operation_i == ALU_SRL);

  alu_shift_iter u_shift (
    .clk        (clk),
    .reset      (reset),
    .load       (sh_load_c),
    .step       (sh_step_c),
    .load_value (bus.a_i),
    .load_count (shamt_c),
    .load_left  (bus.alu_operation_i == ALU_SLL),
    .value_c    (sh_value_c),
    .last_c     (sh_last_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Zero-amount shifts take the single-cycle path.
  always_comb begin
    state_next  = state;
    result_we_c = 1'b0;
    result_d_c  = op_result_c;
    sh_load_c   = 1'b0;
    sh_step_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          if (is_shift_c && (shamt_c != '0)) begin
            sh_load_c  = 1'b1;
            state_next = SHIFT;
          end else begin
            result_we_c = 1'b1;
          end
        end
      end
      SHIFT: begin
        sh_step_c = 1'b1;
        if (sh_last_c) begin
          result_we_c = 1'b1;
          result_d_c  = sh_value_c;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy_o = (state == SHIFT);

`endif

  // Result and zero flag only move on a completion or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
    end else begin
      done <= result_we_c;
      if (result_we_c) begin
        result <= result_d_c;
        zero   <= (result_d_c == '0);
      end
    end
  end

  assign bus.done_o       = done;
  assign bus.alu_result_o = result;
  assign bus.zero_o       = zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: latency-level reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_alu_exec_unit;

  logic clk;
  logic reset;
  alu_exec_unit_if bus();

  alu_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] golden(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0100: return a - b;
      4'b1001: return a & b;
      4'b0010: return a | b;
      4'b0110: return a ^ b;
      4'b0111: return a ^ b;
      4'b1000: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0001: return b;
      4'b1111: return a + 32'd4;
      4'b0011: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Cycles from the start edge until done_o is visible.
  function automatic int lat_of(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if ((op == 4'b0011 || op == 4'b0101) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Reference model: tracks remaining busy cycles and the pending answer.
  int          cyc = 0;
  int          m_busy_left = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_res = '0;
  logic        m_zero = 1'b1;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    logic [31:0] r;
    int          lat;
    cyc <= cyc + 1;
    if (reset) begin
      m_res <= 32'd0; m_zero <= 1'b1; m_done <= 1'b0; m_busy_left <= 0;
    end else if (m_busy_left > 0) begin
      m_busy_left <= m_busy_left - 1;
      m_done      <= (m_busy_left == 1);
      if (m_busy_left == 1) begin
        m_res  <= m_pend;
        m_zero <= (m_pend == 32'd0);
      end
    end else if (bus.start_i) begin
      r   = golden(bus.alu_operation_i, bus.a_i, bus.b_i);
      lat = lat_of(bus.alu_operation_i, bus.b_i);
      if (lat == 1) begin
        m_res <= r; m_zero <= (r == 32'd0); m_done <= 1'b1;
      end else begin
        m_pend <= r; m_busy_left <= lat - 1; m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("cmp done", 32'(bus.done_o), 32'(m_done));
      check("cmp busy", 32'(bus.busy_o), 32'(m_busy_left > 0));
      check("cmp result", bus.alu_result_o, m_res);
      check("cmp zero", 32'(bus.zero_o), 32'(m_zero));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i = 1'b1; bus.alu_operation_i = op; bus.a_i = a; bus.b_i = b;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic [31:0] exp_res,
                           input logic exp_zero);
    int n;
    n = 1;
    while (bus.done_o !== 1'b1 && n <= 64) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " result"}, bus.alu_result_o, exp_res);
    check({name, " zero"}, 32'(bus.zero_o), 32'(exp_zero));
  endtask

  task automatic op_check(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero);
    issue(op, a, b);
    wait_done(name, lat_of(op, b), exp_res, exp_zero);
  endtask

  initial begin
    int n;
    int nb;
    reset = 1'b1;
    bus.start_i = 1'b0; bus.alu_operation_i = 4'd0; bus.a_i = '0; bus.b_i = '0;
    repeat (3) @(negedge clk);
    check("reset result", bus.alu_result_o, 32'd0);
    check("reset zero", 32'(bus.zero_o), 32'd1);
    check("reset done", 32'(bus.done_o), 32'd0);
    check("reset busy", 32'(bus.busy_o), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    op_check("add", 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0);
    op_check("sub", 4'b0100, 32'd9, 32'd9, 32'd0, 1'b1);
    op_check("bne", 4'b0111, 32'd3, 32'd5, 32'd6, 1'b0);
    op_check("blt neg", 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    op_check("blt pos", 4'b1000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    op_check("jal", 4'b1111, 32'h0000_0100, 32'd0, 32'h0000_0104, 1'b0);
    op_check("lui", 4'b0001, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1'b0);
    op_check("and", 4'b1001, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
    op_check("or", 4'b0010, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0);
    op_check("xor", 4'b0110, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0);
    op_check("undef op", 4'b1010, 32'd7, 32'd9, 32'd0, 1'b1);
    op_check("add wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    op_check("sll shamt0", 4'b0011, 32'h0000_ABCD, 32'h0000_0020, 32'h0000_ABCD, 1'b0);
    op_check("srl 1", 4'b0101, 32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 1'b0);

    // Back-to-back single-cycle ops.
    bus.start_i = 1'b1; bus.alu_operation_i = 4'b0000; bus.a_i = 32'd1; bus.b_i = 32'd2;
    @(negedge clk);
    check("b2b first", bus.alu_result_o, 32'd3);
    bus.alu_operation_i = 4'b0010; bus.a_i = 32'h10; bus.b_i = 32'h01;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("b2b second", bus.alu_result_o, 32'h11);
    check("b2b done", 32'(bus.done_o), 32'd1);

    // Long shift with an ADD request during busy that must be dropped.
    issue(4'b0011, 32'd1, 32'd31);
    n = 1; nb = 0;
    while (bus.done_o !== 1'b1 && n <= 64) begin
      if (bus.busy_o === 1'b1) nb++;
      if (n == 3) begin
        bus.start_i = 1'b1; bus.alu_operation_i = 4'b0000; bus.a_i = 32'd2; bus.b_i = 32'd2;
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start_i = 1'b0;
    check("sll31 latency", 32'(n), 32'(lat_of(4'b0011, 32'd31)));
    check("sll31 busy cycles", 32'(nb), 32'(lat_of(4'b0011, 32'd31) - 1));
    check("sll31 result", bus.alu_result_o, 32'h8000_0000);
    @(negedge clk);
    check("ignored add done", 32'(bus.done_o), 32'd0);
    check("ignored add result", bus.alu_result_o, 32'h8000_0000);

    // SRL then an ADD issued in the done cycle.
    op_check("srl4", 4'b0101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0);
    op_check("add in done", 4'b0000, 32'd10, 32'd20, 32'd30, 1'b0);

    // Reset on the third busy cycle aborts the shift.
    issue(4'b0011, 32'd1, 32'd10);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort done", 32'(bus.done_o), 32'd0);
    check("abort busy", 32'(bus.busy_o), 32'd0);
    check("abort result", bus.alu_result_o, 32'd0);
    check("abort zero", 32'(bus.zero_o), 32'd1);
    repeat (12) @(negedge clk);
    check("abort no late done", 32'(bus.done_o), 32'd0);
    op_check("add after abort", 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
